regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, write-data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester 0 (pipeline WB) / requester 1 (multi-cycle unit) write request.
REQ-005 The block SHALL have ports req0_addr / req1_addr, input, 5 each, destination register number.
REQ-006 The block SHALL have ports req0_data / req1_data, input, DATA_W each, write data.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 each; a request is accepted when valid and ready are both high on the same edge.
REQ-008 The block SHALL have port wr_hold, input, 1; when high, the register file is not committing this cycle.
REQ-009 The block SHALL have ports wr_en (1), wr_addr (5) and wr_data (DATA_W), outputs, all registered; they feed the 5:32 write-enable decoder and the register-file data port.
REQ-010 The block SHALL have port last_grant, output, 1, index of the requester most recently accepted.

Function
REQ-011 Output slot free = !wr_en | !wr_hold; readys SHALL be combinational from the current valids, the slot-free condition and last_grant.
REQ-012 At most one requester SHALL be ready per cycle; when the slot is not free both readys SHALL be 0.
REQ-013 If only one requester is valid and the slot is free, that requester SHALL be ready.
REQ-014 If both are valid and the slot is free, the winner SHALL be chosen per REQ-025/026; the loser's ready SHALL be 0, and it keeps valid, addr and data stable until it is accepted.
REQ-015 On acceptance at edge N, wr_addr and wr_data SHALL take the accepted values and wr_en SHALL be 1 in cycle N+1 (latency 1), except as in REQ-017.
REQ-016 While wr_en=1 and wr_hold=1, wr_en, wr_addr and wr_data SHALL hold stable and no request SHALL be accepted.
REQ-017 A request with addr 5'd31 (XZR) SHALL be accepted normally, but wr_en SHALL be 0 in the following cycle; wr_addr and wr_data still update.
REQ-018 If no request is accepted on an edge and the slot is free, wr_en SHALL be 0 in the next cycle.
REQ-019 Back-to-back acceptances SHALL sustain one write per cycle while wr_hold=0.
REQ-020 Simultaneous requests to the same address SHALL be written in grant order; the later write overwrites.
REQ-021 last_grant SHALL update only on acceptance.

Reset
REQ-022 While reset=1 on an edge, wr_en SHALL become 0, and wr_addr and wr_data SHALL become 0.
REQ-023 While reset=1 on an edge, last_grant SHALL become 1, so requester 0 wins the first tie.
REQ-024 Both readys SHALL be 0 while reset=1; reset mid-hold SHALL discard the held write.

Configuration
REQ-025 With RFW_ROUND_ROBIN_EN defined, the tie winner SHALL be the requester not equal to last_grant.
REQ-026 Without RFW_ROUND_ROBIN_EN, requester 0 SHALL always win ties; last_grant SHALL still be tracked.

Verification
REQ-027 Scenario: reset, then req0 addr=5 data=0xA5 for one cycle -> next cycle wr_en=1, wr_addr=5, wr_data=0xA5; the cycle after, wr_en=0.
REQ-028 Scenario: both valid for 4 cycles (addr 3 and 7) with the macro on -> grants 0,1,0,1; with the macro off -> grant 0 every cycle while req0 is valid.
REQ-029 Scenario: wr_hold=1 for 3 cycles with wr_en=1 and req1 pending -> outputs frozen, req1_ready=0; once hold drops, req1 is accepted and written 1 cycle later.
REQ-030 Scenario: req1 addr=31 data=0xFF -> accepted, and the next cycle wr_en=0 with wr_addr=31.
REQ-031 Scenario: reset asserted while wr_en=1 and wr_hold=1 -> next cycle wr_en=0, wr_addr=0, last_grant=1, both readys 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: two write requesters plus the registered
// commit port that feeds the write-enable decoder and the data port.
// The arbiter connects through the slave modport; the requesters and the
// register file connect through the master modport.
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 64
);
    // Requester 0: pipeline writeback
    logic              req0_valid;
    logic              req0_ready;
    logic [4:0]        req0_addr;
    logic [DATA_W-1:0] req0_data;
    // Requester 1: multi-cycle unit
    logic              req1_valid;
    logic              req1_ready;
    logic [4:0]        req1_addr;
    logic [DATA_W-1:0] req1_data;
    // Register-file commit port
    logic              wr_hold;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              last_grant;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  wr_hold,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, last_grant
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output wr_hold,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, last_grant
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter in front of a single register-file write port.
// Requester 0 (pipeline WB) and requester 1 (multi-cycle unit) compete for one
// registered write slot. The slot is free unless a write is pending and the
// register file is holding it. Writes to register 31 (XZR) are accepted but
// never enabled.
// Optional feature: define RFW_ROUND_ROBIN_EN to alternate tie winners;
// otherwise requester 0 always wins ties.
module regfile_wr_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);

    localparam logic [4:0] XZR_ADDR = 5'd31;

    logic              wr_en_q,      wr_en_d;
    logic [4:0]        wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,    wr_data_d;
    logic              last_grant_q, last_grant_d;

    logic slot_free;
    logic tie_pick1;
    logic grant0;
    logic grant1;

    // Slot availability and grant selection; readys are purely combinational.
    always_comb begin
        slot_free = !wr_en_q || !bus.wr_hold;
`ifdef RFW_ROUND_ROBIN_EN
        // Tie goes to whichever requester was not granted last.
        tie_pick1 = !last_grant_q;
`else
        tie_pick1 = 1'b0;
`endif
        grant0 = !reset && slot_free && bus.req0_valid && (!bus.req1_valid || !tie_pick1);
        grant1 = !reset && slot_free && bus.req1_valid && (!bus.req0_valid ||  tie_pick1);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Next-state for the write port and grant history.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            wr_en_d      = (bus.req0_addr != XZR_ADDR);
            wr_addr_d    = bus.req0_addr;
            wr_data_d    = bus.req0_data;
            last_grant_d = 1'b0;
        end else if (grant1) begin
            wr_en_d      = (bus.req1_addr != XZR_ADDR);
            wr_addr_d    = bus.req1_addr;
            wr_data_d    = bus.req1_data;
            last_grant_d = 1'b1;
        end else if (slot_free) begin
            // Slot drained with nothing new: drop the enable, keep addr/data.
            wr_en_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held write is discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter.
// A directed table drives one row per cycle and pushes the row (which carries
// hand-computed expected readys and post-edge outputs) into a scoreboard
// queue; a monitor process pops each row and compares the DUT against it.
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 64;

`ifdef RFW_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic              rst;
        logic              hold;
        logic              v0;
        logic [4:0]        a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [4:0]        a1;
        logic [DATA_W-1:0] d1;
        logic              er0;
        logic              er1;
        logic              een;
        logic [4:0]        eaddr;
        logic [DATA_W-1:0] edata;
        logic              chk_ad;
        logic              elg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    regfile_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regfile_wr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic hold,
        input logic v0, input logic [4:0] a0, input logic [DATA_W-1:0] d0,
        input logic v1, input logic [4:0] a1, input logic [DATA_W-1:0] d1,
        input logic er0, input logic er1, input logic een,
        input logic [4:0] eaddr, input logic [DATA_W-1:0] edata,
        input logic chk_ad, input logic elg);
        vec_t v;
        v.rst = rst;  v.hold = hold;
        v.v0 = v0;    v.a0 = a0;    v.d0 = d0;
        v.v1 = v1;    v.a1 = a1;    v.d1 = d1;
        v.er0 = er0;  v.er1 = er1;  v.een = een;
        v.eaddr = eaddr; v.edata = edata; v.chk_ad = chk_ad; v.elg = elg;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset          = v.rst;
        bus.wr_hold    = v.hold;
        bus.req0_valid = v.v0;
        bus.req0_addr  = v.a0;
        bus.req0_data  = v.d0;
        bus.req1_valid = v.v1;
        bus.req1_addr  = v.a1;
        bus.req1_data  = v.d1;
    endtask

    // Directed table: each row = inputs for one cycle, expected readys in that
    // cycle, and expected registered outputs after the following rising edge.
    task automatic build_vectors();
        //            rst hold v0 a0    d0      v1 a1     d1      r0 r1 en addr   data    chk lg
        vecs.push_back(mk(1, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  1, 1));
        vecs.push_back(mk(1, 0, 1, 5'd5, 64'hA5, 0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  1, 1));
        // Single write, latency 1, then enable drops
        vecs.push_back(mk(0, 0, 1, 5'd5, 64'hA5, 0, 5'd0,  64'h0,  1, 0, 1, 5'd5,  64'hA5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  0, 0));
        // Requester 1 alone sets last_grant=1 before the tie run
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  1, 5'd9,  64'h99, 0, 1, 1, 5'd9,  64'h99, 1, 1));
        // Four tie cycles: RR alternates 0,1,0,1; fixed priority gives 0 every time
        for (int i = 0; i < 4; i++) begin
            bit odd;
            odd = RR && (i % 2 == 1);
            vecs.push_back(mk(0, 0, 1, 5'd3, 64'h33, 1, 5'd7, 64'h77,
                              !odd, odd, 1, odd ? 5'd7 : 5'd3, odd ? 64'h77 : 64'h33, 1, odd));
        end
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  0, RR));
        // Write pending, then 3 hold cycles with req1 waiting: outputs frozen
        vecs.push_back(mk(0, 0, 1, 5'd1, 64'h11, 0, 5'd0,  64'h0,  1, 0, 1, 5'd1,  64'h11, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 0, 5'd0, 64'h0, 1, 5'd2, 64'h22, 0, 0, 1, 5'd1, 64'h11, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  1, 5'd2,  64'h22, 0, 1, 1, 5'd2,  64'h22, 1, 1));
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  0, 1));
        // Hold with wr_en=0 leaves the slot free; a second request is then blocked
        vecs.push_back(mk(0, 1, 1, 5'd4, 64'h44, 0, 5'd0,  64'h0,  1, 0, 1, 5'd4,  64'h44, 1, 0));
        vecs.push_back(mk(0, 1, 1, 5'd6, 64'h66, 0, 5'd0,  64'h0,  0, 0, 1, 5'd4,  64'h44, 1, 0));
        // XZR write: accepted, addr/data update, enable stays low
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  1, 5'd31, 64'hFF, 0, 1, 0, 5'd31, 64'hFF, 1, 1));
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  0, 1));
        // Reset while a write is held: write discarded, last_grant back to 1
        vecs.push_back(mk(0, 0, 1, 5'd8, 64'h88, 0, 5'd0,  64'h0,  1, 0, 1, 5'd8,  64'h88, 1, 0));
        vecs.push_back(mk(1, 1, 0, 5'd0, 64'h0,  1, 5'd2,  64'h22, 0, 0, 0, 5'd0,  64'h0,  1, 1));
        // First tie after reset goes to requester 0 in either build
        vecs.push_back(mk(0, 0, 1, 5'd3, 64'h33, 1, 5'd7,  64'h77, 1, 0, 1, 5'd3,  64'h33, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5'd0, 64'h0,  0, 5'd0,  64'h0,  0, 0, 0, 5'd0,  64'h0,  0, 0));
    endtask

    // Stimulus: drive one row per cycle just after the falling edge.
    initial begin
        vec_t idle;
        idle = mk(1, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0, 0, 5'd0, 64'h0, 0, 1);
        drive(idle);
        build_vectors();
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
        end
        @(negedge clk);
        idle.rst = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d rows left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: readys sampled mid-cycle, registered outputs sampled after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                vec_t e;
                e = exp_q.pop_front();
                check("req0_ready", DATA_W'(bus.req0_ready), DATA_W'(e.er0));
                check("req1_ready", DATA_W'(bus.req1_ready), DATA_W'(e.er1));
                @(posedge clk);
                #1;
                check("wr_en",      DATA_W'(bus.wr_en),      DATA_W'(e.een));
                check("last_grant", DATA_W'(bus.last_grant), DATA_W'(e.elg));
                if (e.chk_ad) begin
                    check("wr_addr", DATA_W'(bus.wr_addr), DATA_W'(e.eaddr));
                    check("wr_data", bus.wr_data, e.edata);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
